operand_sequencer: RTL
======================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width of operands and sum.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_data, input, WIDTH bits: the operand byte stream, A first, then B.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 SHALL have port add_a, output, WIDTH bits: operand A, driven to the downstream combinational adder.
REQ-008 SHALL have port add_b, output, WIDTH bits: operand B, driven to the downstream combinational adder.
REQ-009 SHALL have port add_sum, input, WIDTH bits: the adder result, combinational from add_a/add_b.
REQ-010 SHALL have port out_sum, output, WIDTH bits: the registered result.
REQ-011 SHALL have port out_valid, output, 1 bit: out_sum holds a valid result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts out_sum.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except GET_A.

Function
REQ-014 SHALL implement the FSM states GET_A, GET_B, CALC and OUT (binary encoded).
REQ-015 SHALL hold in GET_A: in_ready=1; on in_valid&in_ready, a_reg<=in_data, next state GET_B; otherwise stay.
REQ-016 SHALL hold in GET_B: in_ready=1; on in_valid&in_ready, b_reg<=in_data, next state CALC; otherwise stay, with a_reg held.
REQ-017 SHALL hold in CALC: in_ready=0; sum_reg<=add_sum; next state OUT unconditionally.
REQ-018 SHALL hold in OUT: in_ready=0 and out_valid=1; on out_ready, next state GET_A; otherwise hold out_sum stable.
REQ-019 SHALL drive add_a=a_reg and add_b=b_reg continuously; out_sum=sum_reg.
REQ-020 SHALL compute the sum modulo 2^WIDTH; carry is discarded unless REQ-026 applies.
REQ-021 SHALL have a latency of B accepted at edge N -> sum captured at edge N+1 -> out_valid high from edge N+1 until the accepting edge.
REQ-022 SHALL not overlap transactions: in_ready=0 in CALC and OUT; in_data is ignored there regardless of in_valid.
REQ-023 SHALL set out_valid only in OUT; out_valid SHALL not drop without out_ready.
REQ-024 SHALL, in GET_A, give minimum throughput of one result per 4 cycles (A, B, CALC, OUT with out_ready=1).

Reset
REQ-025 SHALL, while rst=1, immediately and asynchronously force state=GET_A, a_reg=b_reg=sum_reg=0, out_valid=0, busy=0, and in_ready=1 after release. A reset mid-transaction SHALL discard partial operands; the first beat after release is A.

Configuration
REQ-026 SHALL, with macro OPERAND_SEQUENCER_CARRY_EN defined, add output carry_out (1 bit), registered in CALC as (add_sum < a_reg), valid with out_valid, and reset to 0.
REQ-027 SHALL, without OPERAND_SEQUENCER_CARRY_EN, omit the carry_out port and its logic entirely.

Verification
REQ-028 SHALL cover: in_data 3 then 5 back-to-back, out_ready=1 -> out_sum=8, out_valid for exactly 1 cycle, 4-cycle period.
REQ-029 SHALL cover: 200 then 100 -> out_sum=44; with CARRY_EN, carry_out=1; 255+0 -> 255, carry_out=0.
REQ-030 SHALL cover: out_ready=0 for 5 cycles after result 0x10 -> out_valid and out_sum held, in_ready=0, in_valid pulses ignored.
REQ-031 SHALL cover: in_valid gaps of 3 cycles between A=7 and B=9 -> out_sum=16, busy high from A acceptance.
REQ-032 SHALL cover: rst asserted after A=0x55 accepted -> outputs cleared asynchronously; next A=1,B=2 -> out_sum=3.

Source files
------------

// File: rtl/operand_sequencer.sv
// operand_sequencer
// -----------------------------------------------------------------------------
// Collects two operands (A then B) from a valid/ready byte stream, presents
// them to an external combinational adder, registers the adder's result and
// holds it on a valid/ready output until the consumer takes it. Only one
// transaction is in flight at a time: A, B, CALC, OUT, then back to A.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge
// where valid and ready are both high. The producer may assert valid at any
// time. Once this block raises out_valid, it keeps out_valid and out_sum
// stable until the edge where out_ready is sampled high.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset
//   in_data      in   operand stream, A first, then B
//   in_valid     in   in_data valid this cycle
//   in_ready     out  block accepts in_data this cycle (GET_A / GET_B)
//   add_a        out  operand A, to the external adder
//   add_b        out  operand B, to the external adder
//   add_sum      in   adder result, combinational from add_a/add_b
//   out_sum      out  registered result
//   out_valid    out  out_sum holds a valid result (OUT state only)
//   out_ready    in   consumer accepts out_sum
//   busy         out  high in every state except GET_A
//   carry_out    out  carry of A+B, valid with out_valid
//                     (present only with OPERAND_SEQUENCER_CARRY_EN defined)
//   state_dbg_o  out  current FSM state, for observation
//
// Build option: define OPERAND_SEQUENCER_CARRY_EN to add the carry_out port.
// -----------------------------------------------------------------------------
module operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef OPERAND_SEQUENCER_CARRY_EN
  output logic             carry_out,
`endif
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    CALC  = 2'd2,
    OUT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef OPERAND_SEQUENCER_CARRY_EN
  logic             carry_q, carry_d;
`endif

  // Next-state and datapath logic. The status outputs are decoded from the
  // next state so that, once registered, they line up with the state they
  // describe.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef OPERAND_SEQUENCER_CARRY_EN
    carry_d = carry_q;
`endif

    unique case (state_q)
      GET_A: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (in_valid && in_ready_q) begin
          b_d     = in_data;
          state_d = CALC;
        end
      end
      CALC: begin
        // add_a/add_b have been stable since B was accepted, so add_sum has
        // settled by now. The sum wraps modulo 2^WIDTH.
        sum_d   = add_sum;
`ifdef OPERAND_SEQUENCER_CARRY_EN
        // An unsigned wrap-around leaves the truncated sum below operand A.
        carry_d = (add_sum < a_q);
`endif
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase

    in_ready_d  = (state_d == GET_A) || (state_d == GET_B);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != GET_A);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef OPERAND_SEQUENCER_CARRY_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef OPERAND_SEQUENCER_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign add_a       = a_q;
  assign add_b       = b_q;
  assign out_sum     = sum_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign state_dbg_o = state_q;
`ifdef OPERAND_SEQUENCER_CARRY_EN
  assign carry_out   = carry_q;
`endif

endmodule
